// File: rtl/rtype_exec_sequencer_if.sv
// Instruction handshake plus register-file/ALU control bundle for rtype_exec_sequencer.
// master = the sequencer, slave = instruction source / register file / ALU side.
interface rtype_exec_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RF_AW  = 5
);
  logic              instr_valid;
  logic [31:0]       instr;
  logic              instr_ready;
  logic [RF_AW-1:0]  rf_raddr1;
  logic [RF_AW-1:0]  rf_raddr2;
  logic [RF_AW-1:0]  rf_waddr;
  logic              rf_we;
  logic [5:0]        alu_funct;
  logic [4:0]        alu_shamt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_ovf;
  logic [DATA_W-1:0] result;
  logic              busy;
  logic              done;
  logic              illegal;
  logic              ovf_trap;

  modport master (
    input  instr_valid, instr, alu_result, alu_ovf,
    output instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_we,
           alu_funct, alu_shamt, result, busy, done, illegal, ovf_trap
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_ovf,
    input  instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_we,
           alu_funct, alu_shamt, result, busy, done, illegal, ovf_trap
  );
endinterface

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle R-type sequencer: IDLE -> DECODE -> READ -> EXEC(xN) -> WB, or DECODE -> FAULT.
// Optional overflow trap on add/sub enabled by defining RTYPE_OVF_TRAP_EN.
module rtype_exec_sequencer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RF_AW       = 5,
  parameter int unsigned EXEC_CYCLES = 1   // legal range 1..15
) (
  input  logic                   clk,
  input  logic                   rst,
  rtype_exec_sequencer_if.master bus
);

  localparam int unsigned CNT_W = 4;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB, S_FAULT
  } state_e;

  state_e            state_q;
  logic [31:0]       instr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q, busy_q, done_q, illegal_q, ovf_trap_q, rf_we_q;
  logic [RF_AW-1:0]  raddr1_q, raddr2_q, waddr_q;
  logic [5:0]        funct_q;
  logic [4:0]        shamt_q;
  logic [DATA_W-1:0] result_q;

  logic              instr_legal;
  logic              rd_nonzero;
  logic              ovf_trap_d;

  // Decode of the captured word; only opcode 0 with a supported funct proceeds.
  always_comb begin
    instr_legal = 1'b0;
    if (instr_q[31:26] == 6'd0) begin
      case (instr_q[5:0])
        F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_SLL, F_SRL: instr_legal = 1'b1;
        default:                                              instr_legal = 1'b0;
      endcase
    end
  end

  assign rd_nonzero = (instr_q[15:11] != 5'd0);

`ifdef RTYPE_OVF_TRAP_EN
  assign ovf_trap_d = bus.alu_ovf && ((instr_q[5:0] == F_ADD) || (instr_q[5:0] == F_SUB));
`else
  assign ovf_trap_d = bus.alu_ovf & 1'b0;
`endif

  // Outputs are registered on the edge that enters the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      ovf_trap_q <= 1'b0;
      rf_we_q    <= 1'b0;
      raddr1_q   <= '0;
      raddr2_q   <= '0;
      waddr_q    <= '0;
      funct_q    <= '0;
      shamt_q    <= '0;
      result_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
      ovf_trap_q <= 1'b0;
      rf_we_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (instr_legal) begin
            raddr1_q <= RF_AW'(instr_q[25:21]);
            raddr2_q <= RF_AW'(instr_q[20:16]);
            waddr_q  <= RF_AW'(instr_q[15:11]);
            shamt_q  <= instr_q[10:6];
            funct_q  <= instr_q[5:0];
            state_q  <= S_READ;
          end else begin
            done_q    <= 1'b1;
            illegal_q <= 1'b1;
            state_q   <= S_FAULT;
          end
        end
        S_READ: begin
          cnt_q   <= CNT_W'(EXEC_CYCLES - 1);
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            result_q   <= bus.alu_result;
            done_q     <= 1'b1;
            ovf_trap_q <= ovf_trap_d;
            rf_we_q    <= rd_nonzero && !ovf_trap_d;
            state_q    <= S_WB;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WB, S_FAULT: begin
          raddr1_q <= '0;
          raddr2_q <= '0;
          waddr_q  <= '0;
          funct_q  <= '0;
          shamt_q  <= '0;
          ready_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = ready_q;
  assign bus.rf_raddr1   = raddr1_q;
  assign bus.rf_raddr2   = raddr2_q;
  assign bus.rf_waddr    = waddr_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.alu_funct   = funct_q;
  assign bus.alu_shamt   = shamt_q;
  assign bus.result      = result_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.illegal     = illegal_q;
  assign bus.ovf_trap    = ovf_trap_q;

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Scoreboard bench for rtype_exec_sequencer: randomized R-type stream against a
// register-file/ALU reference model, plus directed latency, back-to-back and reset cases.
`timescale 1ns/1ps
module tb_rtype_exec_sequencer;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RF_AW  = 5;
  localparam int unsigned EXEC_N = 3;
`ifdef RTYPE_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    int unsigned done_cyc;
    bit          illegal;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] result;
    bit          trap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          mon_en = 1'b0;

  logic [31:0] tb_rf    [32];
  logic [31:0] model_rf [32];
  logic [31:0] last_result = '0;
  exp_t        sb_q [$];

  bit          have_cur = 1'b0;
  bit          cur_legal;
  int unsigned cur_a, cur_done;
  logic [4:0]  cur_rs, cur_rt, cur_rd, cur_sh;
  logic [5:0]  cur_f;
  int unsigned last_accept;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rtype_exec_sequencer_if #(.DATA_W(DATA_W), .RF_AW(RF_AW)) bus ();

  rtype_exec_sequencer #(.DATA_W(DATA_W), .RF_AW(RF_AW), .EXEC_CYCLES(EXEC_N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic logic [31:0] init_val(input int unsigned i);
    case (i)
      0:       return 32'h0;
      1:       return 32'd5;
      2:       return 32'd7;
      4:       return 32'h7fff_ffff;
      5:       return 32'd1;
      6:       return 32'h8000_0000;
      default: return 32'(i * 32'h9E37_79B9) ^ 32'h1234_5678;
    endcase
  endfunction

  // Returns {overflow, result}; signed overflow = wide sum not representable in 32 bits.
  function automatic logic [32:0] alu_ref(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, wide;
    logic [31:0] r;
    bit ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ovf = 1'b0;
    case (f)
      6'h20: begin wide = sa + sb; r = 32'(wide); ovf = (wide != longint'($signed(r))); end
      6'h22: begin wide = sa - sb; r = 32'(wide); ovf = (wide != longint'($signed(r))); end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h27: r = ~(a | b);
      6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
      6'h00: r = b << sh;
      6'h02: r = b >> sh;
      default: r = 32'hDEAD_BEEF;
    endcase
    return {ovf, r};
  endfunction

  // Environment: register file written on rf_we, combinational ALU fed by the read ports.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= init_val(i);
    end else if (bus.rf_we && bus.rf_waddr != 5'd0) begin
      tb_rf[bus.rf_waddr] <= bus.alu_result;
    end
  end

  always_comb begin
    logic [32:0] o;
    o = alu_ref(bus.alu_funct, bus.alu_shamt, tb_rf[bus.rf_raddr1], tb_rf[bus.rf_raddr2]);
    bus.alu_ovf    = o[32];
    bus.alu_result = o[31:0];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: architectural effect of one instruction, computed at accept time.
  task automatic push_expect(input logic [31:0] w, input int unsigned a);
    exp_t e;
    logic [32:0] o;
    bit legal;
    legal = (w[31:26] == 6'd0) &&
            (w[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02});
    e.illegal = !legal;
    e.rd      = w[15:11];
    e.we      = 1'b0;
    e.trap    = 1'b0;
    if (legal) begin
      o = alu_ref(w[5:0], w[10:6], model_rf[w[25:21]], model_rf[w[20:16]]);
      e.trap = TRAP_EN && o[32] && (w[5:0] == 6'h20 || w[5:0] == 6'h22);
      e.we   = (w[15:11] != 5'd0) && !e.trap;
      if (e.we) model_rf[w[15:11]] = o[31:0];
      last_result = o[31:0];
      e.done_cyc = a + 2 + EXEC_N;
    end else begin
      e.done_cyc = a + 1;
    end
    e.result  = last_result;
    cur_legal = legal;
    cur_rs = w[25:21]; cur_rt = w[20:16]; cur_rd = w[15:11]; cur_sh = w[10:6]; cur_f = w[5:0];
    cur_a = a;
    cur_done = e.done_cyc;
    have_cur = 1'b1;
    sb_q.push_back(e);
  endtask

  // Called just after a rising edge; returns after the accepting edge.
  task automatic send(input logic [31:0] w, input bit keep_valid);
    int n;
    bus.instr = w;
    bus.instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready) begin
      n++;
      if (n > 60) begin
        checks++;
        $display("FAIL accept_timeout: instr_ready stayed 0 for %0d cycles", n);
        bus.instr_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    last_accept = cyc + 1;
    push_expect(w, cyc + 1);
    @(posedge clk);
    #1;
    if (!keep_valid) bus.instr_valid = 1'b0;
  endtask

  // Monitor: per-cycle handshake/address checks and scoreboard pop on done.
  always @(negedge clk) begin
    bit eb, win;
    exp_t e;
    if (mon_en) begin
      eb  = have_cur && cyc >= cur_a && cyc <= cur_done;
      win = have_cur && cur_legal && cyc >= cur_a + 1 && cyc <= cur_done;
      chk("busy", bus.busy, eb);
      chk("instr_ready", bus.instr_ready, !eb);
      chk("rf_raddr1", bus.rf_raddr1, win ? cur_rs : 5'd0);
      chk("rf_raddr2", bus.rf_raddr2, win ? cur_rt : 5'd0);
      chk("rf_waddr", bus.rf_waddr, win ? cur_rd : 5'd0);
      chk("alu_funct", bus.alu_funct, win ? cur_f : 6'd0);
      chk("alu_shamt", bus.alu_shamt, win ? cur_sh : 5'd0);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: done=1 with no instruction outstanding (cycle %0d)", cyc);
        end else begin
          e = sb_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
          chk("illegal", bus.illegal, e.illegal);
          chk("rf_we_wb", bus.rf_we, e.we);
          chk("result", bus.result, e.result);
          chk("ovf_trap", bus.ovf_trap, e.trap);
        end
      end else begin
        chk("rf_we_outside_wb", bus.rf_we, 1'b0);
        if (sb_q.size() > 0 && cyc > sb_q[0].done_cyc) begin
          e = sb_q.pop_front();
          checks++;
          $display("FAIL done_missing: done=0 at cycle %0d, required by cycle %0d", cyc, e.done_cyc);
        end
      end
    end
  end

  initial begin
    logic [5:0] lf [8];
    logic [31:0] w;
    logic [5:0] op, f;
    int unsigned a1, a2, r, n;
    lf = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02};

    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    for (int i = 0; i < 32; i++) model_rf[i] = init_val(i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_ready", bus.instr_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_rf_we", bus.rf_we, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_illegal", bus.illegal, 1'b0);
    chk("rst_ovf_trap", bus.ovf_trap, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;

    send(32'h0022_1820, 1'b0);          // add $3,$1,$2 -> 12
    repeat (8) @(posedge clk);
    #1 send(32'h0022_0020, 1'b0);       // add with rd=0
    repeat (8) @(posedge clk);
    #1 send(32'h8C22_0000, 1'b0);       // non-zero opcode
    repeat (4) @(posedge clk);
    #1 send(32'h0085_1820, 1'b0);       // add overflow: 0x7fffffff + 1
    repeat (8) @(posedge clk);
    #1 send(32'h00C5_3822, 1'b0);       // sub overflow: 0x80000000 - 1
    repeat (8) @(posedge clk);

    #1 send(32'h0022_2024, 1'b1);       // back-to-back with valid held high
    a1 = last_accept;
    send(32'h0043_2825, 1'b0);
    a2 = last_accept;
    chk("b2b_accept_gap", 64'(a2 - a1), 64'(4 + EXEC_N));

    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      r  = $urandom_range(0, 15);
      op = (r == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      f  = (r == 1) ? 6'($urandom) : lf[$urandom_range(0, 7)];
      w  = {op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), f};
      send(w, 1'b0);
    end

    n = 0;
    while (sb_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d expectations never completed", sb_q.size());
    end
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b0;

    // Reset during the second EXEC cycle discards the instruction without a write.
    bus.instr = 32'h0022_2820;
    bus.instr_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.instr_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    a1 = cyc + 1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    while (cyc < a1 + 3) begin
      @(posedge clk);
      #1;
    end
    chk("exec_busy_before_rst", bus.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_instr_ready", bus.instr_ready, 1'b1);
    chk("mid_rst_rf_we", bus.rf_we, 1'b0);
    chk("mid_rst_result", bus.result, 32'h0);
    chk("mid_rst_done", bus.done, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_done", bus.done, 1'b0);
      chk("post_rst_no_we", bus.rf_we, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
